// File: rtl/gtx_link_sequencer.sv
// GTX RX lane bring-up/recovery sequencer: reset, comma search, bit-slide, lock watch.
// Optional error counter enabled by defining LINK_SEQ_ERRCNT_EN.
module gtx_link_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SEARCH_WIN    = 64,
    parameter int unsigned SLIDE_WAIT    = 32,
    parameter int unsigned MAX_SLIDES    = 20,
    parameter int unsigned LOCK_COMMAS   = 4,
    parameter int unsigned COMMA_TIMEOUT = 1023
) (
    input  logic        rxusrclk2,
    input  logic        local_clk_lock,
    input  logic        rx_reset_done,
    input  logic [15:0] rxdata,
    input  logic [1:0]  rxk,
    input  logic        rx_err,
    input  logic        force_relink,
    output logic        gtx_rx_reset,
    output logic        rxslide,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [4:0]  slide_count,
    output logic [7:0]  relink_count,
    output logic [15:0] err_count
);

    localparam int unsigned M1 = (RST_CYCLES > SEARCH_WIN) ? RST_CYCLES : SEARCH_WIN;
    localparam int unsigned M2 = (SLIDE_WAIT > COMMA_TIMEOUT) ? SLIDE_WAIT : COMMA_TIMEOUT;
    localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int GOOD_W = $clog2(LOCK_COMMAS + 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_SEARCH    = 3'd2,
        ST_SLIDE     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_VERIFY    = 3'd5,
        ST_LOCKED    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [4:0]         slide_count_q, slide_count_d;
    logic [7:0]         relink_q, relink_d;
    logic               gtx_rx_reset_q, gtx_rx_reset_d;
    logic               rxslide_q, rxslide_d;
    logic               link_up_q, link_up_d;
    logic               relink_inc;
    logic               slide_go;
    logic               comma_lo;
    logic               comma_hi;

    assign comma_lo = rxk[0] && (rxdata[7:0] == 8'hBC);
    assign comma_hi = rxk[1] && (rxdata[15:8] == 8'hBC);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        good_d        = good_q;
        slide_count_d = slide_count_q;
        relink_inc    = 1'b0;
        slide_go      = 1'b0;

        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (rx_reset_done) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            end
            ST_SEARCH: begin
                if (comma_lo) begin
                    state_d = ST_VERIFY;
                    good_d  = GOOD_W'(1);
                end else if (comma_hi || cnt_q == CNT_W'(SEARCH_WIN - 1)) begin
                    state_d = ST_SLIDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SLIDE: begin
                if (slide_count_q == 5'(MAX_SLIDES)) begin
                    state_d    = ST_RESET;
                    relink_inc = 1'b1;
                end else begin
                    slide_go      = 1'b1;
                    slide_count_d = slide_count_q + 5'd1;
                    state_d       = ST_SETTLE;
                    cnt_d         = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SLIDE_WAIT - 1)) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VERIFY: begin
                if (rx_err || !comma_lo) begin
                    state_d = ST_SLIDE;
                end else if (good_q == GOOD_W'(LOCK_COMMAS - 1)) begin
                    state_d = ST_LOCKED;
                    cnt_d   = '0;
                end else begin
                    good_d = good_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (comma_hi) begin
                    state_d    = ST_RESET;
                    relink_inc = 1'b1;
                end else if (comma_lo) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(COMMA_TIMEOUT - 1)) begin
                    state_d    = ST_RESET;
                    relink_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Global overrides win over anything the state logic decided
        if (force_relink) begin
            state_d    = ST_RESET;
            slide_go   = 1'b0;
            relink_inc = (state_q != ST_RESET);
        end else if (!rx_reset_done && state_q >= ST_SEARCH && state_q <= ST_LOCKED) begin
            state_d       = ST_WAIT_DONE;
            slide_go      = 1'b0;
            relink_inc    = 1'b0;
            slide_count_d = slide_count_q;
        end

        if (state_d == ST_RESET && (state_q != ST_RESET || force_relink)) begin
            cnt_d         = '0;
            slide_count_d = '0;
        end

        relink_d = relink_q;
        if (relink_inc && relink_q != 8'hFF) begin
            relink_d = relink_q + 8'd1;
        end

        rxslide_d      = slide_go;
        link_up_d      = (state_d == ST_LOCKED);
        gtx_rx_reset_d = (state_d == ST_RESET);
    end

    always_ff @(posedge rxusrclk2 or negedge local_clk_lock) begin
        if (!local_clk_lock) begin
            state_q        <= ST_RESET;
            cnt_q          <= '0;
            good_q         <= '0;
            slide_count_q  <= '0;
            relink_q       <= '0;
            gtx_rx_reset_q <= 1'b1;
            rxslide_q      <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            slide_count_q  <= slide_count_d;
            relink_q       <= relink_d;
            gtx_rx_reset_q <= gtx_rx_reset_d;
            rxslide_q      <= rxslide_d;
            link_up_q      <= link_up_d;
        end
    end

`ifdef LINK_SEQ_ERRCNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (link_up_q && rx_err && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge rxusrclk2 or negedge local_clk_lock) begin
        if (!local_clk_lock) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 16'd0;
`endif

    assign state        = state_q;
    assign slide_count  = slide_count_q;
    assign relink_count = relink_q;
    assign gtx_rx_reset = gtx_rx_reset_q;
    assign rxslide      = rxslide_q;
    assign link_up      = link_up_q;

endmodule

// File: doc/gtx_link_sequencer.md
# gtx_link_sequencer

Sequences bring-up and recovery of one GTX receive lane: issues the GTX RX reset, waits for reset completion, bit-slides the deserializer until the 0xBC comma lands in the low byte, confirms lock on consecutive commas, and watches the locked link for comma loss or misalignment. It sits between the GTX RX port and the link-status logic, in the `rxusrclk2` domain, and drives `rxslide` and the GTX RX reset.

## Interface
- `RST_CYCLES`, 16: cycles `gtx_rx_reset` is held high per reset attempt.
- `SEARCH_WIN`, 64: cycles allowed in SEARCH without a low-byte comma before a slide.
- `SLIDE_WAIT`, 32: settle cycles after each `rxslide` pulse.
- `MAX_SLIDES`, 20: slides per attempt before a full GTX reset.
- `LOCK_COMMAS`, 4: consecutive low-byte commas required to declare lock.
- `COMMA_TIMEOUT`, 1023: cycles in LOCKED without a low-byte comma before relink.

Ports:
- `rxusrclk2` in 1: GTX RX user clock. This is the block's only clock.
- `local_clk_lock` in 1: reset. It is asynchronous and active-low.
- `rx_reset_done` in 1: GTX RX reset-done.
- `rxdata` in 16: RX word.
- `rxk` in 2: K-char flags, with bit 0 for the low byte.
- `rx_err` in 1: OR of not-in-table and disparity errors.
- `force_relink` in 1: single-cycle request to restart bring-up.
- `gtx_rx_reset` out 1: GTX RX reset request.
- `rxslide` out 1: one-cycle slide pulse.
- `link_up` out 1: the lane is locked.
- `state` out 3: current state code.
- `slide_count` out 5: slides issued in the current attempt.
- `relink_count` out 8: number of relinks; saturates.
- `err_count` out 16: errors counted while locked; saturates.

## Operation
Definitions:
- "Comma low" means `rxk[0]` is set and `rxdata[7:0]` equals 0xBC.
- "Comma high" means `rxk[1]` is set and `rxdata[15:8]` equals 0xBC.

States and codes:
- RESET (0):
  - `gtx_rx_reset` is 1.
  - Counts RST_CYCLES cycles, then goes to WAIT_DONE.
  - Clears `slide_count` on entry.
- WAIT_DONE (1): goes to SEARCH on the first cycle `rx_reset_done` is 1.
- SEARCH (2):
  - On comma low, goes to VERIFY with the good-comma count set to 1.
  - On comma high, or after SEARCH_WIN cycles with no comma low, goes to SLIDE.
- SLIDE (3):
  - If `slide_count` equals MAX_SLIDES, goes to RESET and increments `relink_count`.
  - Otherwise pulses `rxslide` for one cycle, increments `slide_count`, and goes to SETTLE.
- SETTLE (4): waits SLIDE_WAIT cycles, then goes to SEARCH. Input data is ignored during this state.
- VERIFY (5):
  - Each cycle with comma low increments the good-comma count.
  - When the count reaches LOCK_COMMAS, goes to LOCKED.
  - A cycle without comma low, or any cycle with `rx_err`, goes to SLIDE.
- LOCKED (6):
  - `link_up` is 1.
  - A watchdog counter clears on every comma low.
  - Comma high, or the watchdog reaching COMMA_TIMEOUT, sends the block to RESET and increments `relink_count`.

Global rules, with priority highest first:
1. `force_relink` sends the block from any state to RESET and increments `relink_count`. The increment is skipped if the block is already in RESET.
2. `rx_reset_done` going low in SEARCH through LOCKED sends the block to WAIT_DONE. `relink_count` is not incremented.
3. State-local transitions as listed above.

Counter rules:
- `relink_count` and `err_count` saturate and never wrap.
- `slide_count` is held through LOCKED for diagnostics.

## Timing
- Reset values (while `local_clk_lock` is 0):
  - `state` = RESET, `gtx_rx_reset` = 1.
  - `rxslide`, `link_up`, `slide_count`, `relink_count`, `err_count` are all 0.
  - All internal counters are 0.
- All outputs are registered and change only on the rising edge of `rxusrclk2`.
- Inputs are sampled directly on the clock edge; there is no input pipeline.
- Deciding input to changed output is one edge. For example, the LOCK_COMMAS-th comma low causes `state` = 6 and `link_up` = 1 after the next edge.
- `link_up` falls on the same edge as the exit from LOCKED.
- `rxslide` is high for exactly one cycle per slide. Successive pulses are at least SLIDE_WAIT + 2 cycles apart.
- On release of `local_clk_lock`, RESET runs for a full RST_CYCLES count.

## Configuration
- `LINK_SEQ_ERRCNT_EN` defined:
  - `err_count` increments on each cycle with `rx_err` = 1 while `link_up` = 1.
  - It saturates at 0xFFFF and is cleared only by `local_clk_lock`.
- `LINK_SEQ_ERRCNT_EN` undefined:
  - `err_count` is tied to 0.
  - The counter logic is not synthesized.
  - The port is still present.

## Test plan
- Aligned lock:
  - Stimulus: release reset; `rx_reset_done` rises at cycle 30; continuous comma low from then on.
  - Response: `gtx_rx_reset` high for 16 cycles; `link_up` = 1 four edges after entering SEARCH; `slide_count` = 0.
- Misaligned lock:
  - Stimulus: comma high until 3 slides have been issued, then comma low.
  - Response: exactly 3 one-cycle `rxslide` pulses, each at least 34 cycles apart; lock with `slide_count` = 3.
- Slide exhaustion:
  - Stimulus: never present comma low.
  - Response: 20 pulses, then RESET; `relink_count` = 1; `slide_count` back to 0.
- Comma loss:
  - Stimulus: while LOCKED, stop all commas.
  - Response: `link_up` drops 1023 cycles after the last comma; `state` = 0; `relink_count` increments.
- Relink precedence:
  - Stimulus: `force_relink` and `rx_reset_done` falling in the same cycle while LOCKED.
  - Response: `state` = 0 and `relink_count` increments by 1.
- Error counting (macro defined):
  - Stimulus: 5 `rx_err` cycles while locked, plus 3 `rx_err` cycles while in SEARCH.
  - Response: `err_count` = 5. With the macro undefined, `err_count` = 0.
